// File: rtl/demux_1to2_buf.sv
// rtl/demux_1to2_buf.sv - 1:2 stream demux with one-entry registered output per channel
module demux_1to2_buf #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] m,
    input  logic             s,
    input  logic             m_valid,
    output logic             m_ready,
    output logic [WIDTH-1:0] x,
    output logic             x_valid,
    input  logic             x_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [CNT_W-1:0] x_count,
    output logic [CNT_W-1:0] y_count
);

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_x_valid;
    logic             r_y_valid;
    logic [CNT_W-1:0] r_x_count;
    logic [CNT_W-1:0] r_y_count;

    logic w_x_free;
    logic w_y_free;
    logic w_accept;
    logic w_load_x;
    logic w_load_y;

    // A channel is free when empty or being drained this cycle; m_valid never feeds m_ready.
    assign w_x_free = ~r_x_valid | x_ready;
    assign w_y_free = ~r_y_valid | y_ready;
    assign m_ready  = s ? w_y_free : w_x_free;
    assign w_accept = m_valid & m_ready;
    assign w_load_x = w_accept & ~s;
    assign w_load_y = w_accept & s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_x_valid <= 1'b0;
            r_x_count <= '0;
        end else if (w_load_x) begin
            r_x       <= m;
            r_x_valid <= 1'b1;
            r_x_count <= r_x_count + 1'b1;
        end else if (x_ready) begin
            r_x_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_y_count <= '0;
        end else if (w_load_y) begin
            r_y       <= m;
            r_y_valid <= 1'b1;
            r_y_count <= r_y_count + 1'b1;
        end else if (y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign x_count = r_x_count;
    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign y_count = r_y_count;

endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb/tb_demux_1to2_buf.sv - randomized and directed checks of demux_1to2_buf against a queue model
module tb_demux_1to2_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] m = 2'b00;
    logic       s = 1'b0;
    logic       m_valid = 1'b0;
    logic       x_ready = 1'b0;
    logic       y_ready = 1'b0;
    logic       m_ready, x_valid, y_valid;
    logic [1:0] x, y;
    logic [7:0] x_count, y_count;
    logic       m_ready2, x_valid2, y_valid2;
    logic [1:0] x2, y2;
    logic [1:0] x_count2, y_count2;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] xq[$];
    logic [1:0] yq[$];
    logic [1:0] last_x, last_y;
    int         exp_xc, exp_yc;

    always #5 clk = ~clk;

    demux_1to2_buf #(.WIDTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .m(m), .s(s), .m_valid(m_valid), .m_ready(m_ready),
        .x(x), .x_valid(x_valid), .x_ready(x_ready),
        .y(y), .y_valid(y_valid), .y_ready(y_ready),
        .x_count(x_count), .y_count(y_count)
    );

    demux_1to2_buf #(.WIDTH(2), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .m(m), .s(s), .m_valid(m_valid), .m_ready(m_ready2),
        .x(x2), .x_valid(x_valid2), .x_ready(x_ready),
        .y(y2), .y_valid(y_valid2), .y_ready(y_ready),
        .x_count(x_count2), .y_count(y_count2)
    );

    function automatic bit exp_m_ready();
        if (s) return (yq.size() == 0) || y_ready;
        return (xq.size() == 0) || x_ready;
    endfunction

    function automatic logic [1:0] exp_x();
        return (xq.size() != 0) ? xq[0] : last_x;
    endfunction

    function automatic logic [1:0] exp_y();
        return (yq.size() != 0) ? yq[0] : last_y;
    endfunction

    task automatic model_reset();
        xq.delete();
        yq.delete();
        last_x = 2'b00;
        last_y = 2'b00;
        exp_xc = 0;
        exp_yc = 0;
    endtask

    // Drive inputs at the falling edge so outputs can be compared before the next rising edge.
    task automatic apply(input logic [1:0] mm, input logic ss, input logic mv,
                         input logic xr, input logic yr);
        @(negedge clk);
        m = mm; s = ss; m_valid = mv; x_ready = xr; y_ready = yr;
        #1;
    endtask

    task automatic advance();
        bit acc;
        acc = m_valid && exp_m_ready();
        if (xq.size() != 0 && x_ready) void'(xq.pop_front());
        if (yq.size() != 0 && y_ready) void'(yq.pop_front());
        if (acc && !s) begin
            xq.push_back(m); last_x = m; exp_xc = (exp_xc + 1) % 256;
        end
        if (acc && s) begin
            yq.push_back(m); last_y = m; exp_yc = (exp_yc + 1) % 256;
        end
        @(posedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        m = 2'b00; s = 1'b0; m_valid = 1'b0; x_ready = 1'b0; y_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        apply(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (m_ready !== 1'b1) begin n_err++; $display("FAIL reset_m_ready_idle got %b exp 1", m_ready); end
        advance();
        apply(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (x_valid !== 1'b1 || x !== 2'b11) begin
            n_err++; $display("FAIL reset_preload got x=%b v=%b exp x=11 v=1", x, x_valid);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({x, x_valid, y, y_valid, x_count, y_count} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_async got x=%b xv=%b y=%b yv=%b xc=%0d yc=%0d exp all 0",
                     x, x_valid, y, y_valid, x_count, y_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (m_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_m_ready got %b exp 1", m_ready); end
    endtask

    task automatic test_steering();
        reset_dut();
        apply(2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        advance();
        apply(2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if (x !== 2'b10 || x_valid !== 1'b1) begin
            n_err++; $display("FAIL steer_x got x=%b v=%b exp x=10 v=1", x, x_valid);
        end
        advance();
        apply(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (y !== 2'b01 || y_valid !== 1'b1 || x_valid !== 1'b0 || x !== 2'b10) begin
            n_err++; $display("FAIL steer_y got y=%b yv=%b xv=%b x=%b exp y=01 yv=1 xv=0 x=10", y, y_valid, x_valid, x);
        end
        n_vec++;
        if (x_count !== 8'd1 || y_count !== 8'd1) begin
            n_err++; $display("FAIL steer_counts got xc=%0d yc=%0d exp 1 1", x_count, y_count);
        end
        advance();
    endtask

    task automatic test_stall();
        reset_dut();
        apply(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        advance();
        apply(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (m_ready !== 1'b0 || x !== 2'b11 || x_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_block got rdy=%b x=%b v=%b exp rdy=0 x=11 v=1", m_ready, x, x_valid);
        end
        advance();
        apply(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (m_ready !== 1'b1 || x !== 2'b11 || x_count !== 8'd1) begin
            n_err++; $display("FAIL stall_hold got rdy=%b x=%b xc=%0d exp rdy=1 x=11 xc=1", m_ready, x, x_count);
        end
        advance();
        apply(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (x !== 2'b00 || x_valid !== 1'b1 || x_count !== 8'd2) begin
            n_err++; $display("FAIL stall_release got x=%b v=%b xc=%0d exp x=00 v=1 xc=2", x, x_valid, x_count);
        end
        advance();
    endtask

    task automatic test_cross();
        reset_dut();
        apply(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        advance();
        apply(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (m_ready !== 1'b1) begin n_err++; $display("FAIL cross_m_ready got %b exp 1", m_ready); end
        advance();
        apply(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (y !== 2'b01 || y_valid !== 1'b1 || x !== 2'b11 || x_valid !== 1'b1 || x_count !== 8'd1) begin
            n_err++; $display("FAIL cross_result got y=%b yv=%b x=%b xv=%b xc=%0d exp y=01 yv=1 x=11 xv=1 xc=1",
                              y, y_valid, x, x_valid, x_count);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [1:0] words[10];
        reset_dut();
        for (int i = 0; i < 10; i++) words[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) apply(words[i], 1'b0, 1'b1, 1'b1, 1'b0);
            else        apply(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i > 0) begin
                n_vec++;
                if (x_valid !== 1'b1 || x !== words[i-1] || m_ready !== 1'b1) begin
                    n_err++; $display("FAIL b2b_word%0d got x=%b v=%b rdy=%b exp x=%b v=1 rdy=1",
                                      i - 1, x, x_valid, m_ready, words[i-1]);
                end
            end
            advance();
        end
        apply(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (x_count !== 8'd10 || x_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_count got xc=%0d v=%b exp xc=10 v=0", x_count, x_valid);
        end
        advance();
    endtask

    task automatic test_wrap();
        logic [1:0] seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            apply(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0, 1'b1);
            advance();
            apply(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
            n_vec++;
            if (y_count2 !== seq[i]) begin
                n_err++; $display("FAIL wrap_step%0d got yc=%0d exp %0d", i, y_count2, seq[i]);
            end
        end
        advance();
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            apply(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
            n_vec++;
            if (m_ready !== exp_m_ready() || x !== exp_x() || y !== exp_y() ||
                x_valid !== (xq.size() != 0) || y_valid !== (yq.size() != 0) ||
                x_count !== 8'(exp_xc) || y_count !== 8'(exp_yc) || y_count2 !== 2'(exp_yc % 4)) begin
                n_err++;
                $display("FAIL random_cycle%0d got rdy=%b x=%b xv=%b y=%b yv=%b xc=%0d yc=%0d yc2=%0d exp rdy=%b x=%b xv=%b y=%b yv=%b xc=%0d yc=%0d yc2=%0d",
                         i, m_ready, x, x_valid, y, y_valid, x_count, y_count, y_count2,
                         exp_m_ready(), exp_x(), (xq.size() != 0), exp_y(), (yq.size() != 0),
                         exp_xc, exp_yc, exp_yc % 4);
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_steering();
        test_stall();
        test_cross();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
